// File: rtl/output_writeback.sv
// output_writeback
//   Final stage of the convolution datapath. It collects results from the four
//   z lanes, buffers them per lane, and writes them into the 8-entry output RAM
//   (dom). A single write port is shared between the lanes round-robin.
//
//   Lane i owns RAM addresses i*ELEMS_PER_LANE .. i*ELEMS_PER_LANE+ELEMS_PER_LANE-1.
//   Results from one lane are written in the order they arrived.
//
//   done is raised once every lane has written its full quota.
//   overflow_error is sticky and is set when an incoming result is dropped.
//
//   Ports
//     clk, reset                    clock; synchronous active-high reset
//     start                         one-cycle pulse that begins or restarts a run
//     zN_element, zN_element_ready  lane N result and its one-cycle push strobe
//     dut__dom__address/data        output RAM write address and write data
//     dut__dom__enable/write        RAM enable and write strobe (always identical)
//     done                          every lane written; held until start or reset
//     overflow_error                sticky flag: a push was dropped
//
//   Build option
//     OUTPUT_RELU_EN  when defined, any value with its sign bit set is written as 0.
//                     Otherwise data passes through unmodified.
module output_writeback #(
    parameter int NUM_LANES      = 4,
    parameter int ELEMS_PER_LANE = 2,
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 3,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] z0_element,
    input  logic [DATA_W-1:0] z1_element,
    input  logic [DATA_W-1:0] z2_element,
    input  logic [DATA_W-1:0] z3_element,
    input  logic              z0_element_ready,
    input  logic              z1_element_ready,
    input  logic              z2_element_ready,
    input  logic              z3_element_ready,
    output logic [ADDR_W-1:0] dut__dom__address,
    output logic [DATA_W-1:0] dut__dom__data,
    output logic              dut__dom__enable,
    output logic              dut__dom__write,
    output logic              done,
    output logic              overflow_error
);

    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int CNT_W  = $clog2(ELEMS_PER_LANE + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);

    generate
        if (NUM_LANES != 4) begin : g_bad_lanes
            $error("output_writeback: NUM_LANES must be 4");
        end
        if (NUM_LANES * ELEMS_PER_LANE > (1 << ADDR_W)) begin : g_bad_addr
            $error("output_writeback: lane quotas exceed the RAM address space");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("output_writeback: FIFO_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t            state;
    logic [LANE_W-1:0] rr_ptr;
    logic [DATA_W-1:0] fifo_mem [NUM_LANES][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr   [NUM_LANES];
    logic [PTR_W-1:0]  wr_ptr   [NUM_LANES];
    logic [OCC_W-1:0]  occ      [NUM_LANES];
    logic [CNT_W-1:0]  accepted [NUM_LANES];   // written + buffered
    logic [CNT_W-1:0]  written  [NUM_LANES];

    logic [DATA_W-1:0]    lane_data [NUM_LANES];
    logic [NUM_LANES-1:0] lane_ready;
    logic [NUM_LANES-1:0] push_req, quota_ok, eligible, pop, bypass;
    logic [NUM_LANES-1:0] fifo_push, fifo_pop, push_ok, drop;
    logic                 collecting, run_complete;
    logic [LANE_W-1:0]    cand;
    logic                 vld_p0;
    logic [LANE_W-1:0]    lane_p0;
    logic [DATA_W-1:0]    data_p0;

    assign lane_data[0] = z0_element;
    assign lane_data[1] = z1_element;
    assign lane_data[2] = z2_element;
    assign lane_data[3] = z3_element;
    assign lane_ready   = {z3_element_ready, z2_element_ready, z1_element_ready, z0_element_ready};

    // A start pulse overrides everything else in its cycle, including pushes.
    assign collecting = (state == COLLECT) && !start;

    // ReLU is applied on the way to the RAM, so the buffers hold raw lane values.
    function automatic logic [DATA_W-1:0] writeback_value(input logic signed [DATA_W-1:0] v);
`ifdef OUTPUT_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    always_comb begin
        push_req = '0;
        quota_ok = '0;
        eligible = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            push_req[i] = collecting && lane_ready[i];
            quota_ok[i] = (accepted[i] != CNT_W'(ELEMS_PER_LANE));
            // An empty lane can still win arbitration with a push arriving this
            // cycle. That push bypasses the FIFO, which gives one-cycle latency.
            eligible[i] = collecting && ((occ[i] != '0) || (push_req[i] && quota_ok[i]));
        end

        // Round-robin arbiter: take the first eligible lane at or after rr_ptr.
        // NUM_LANES is a power of two, so the index addition wraps naturally.
        vld_p0  = 1'b0;
        lane_p0 = '0;
        cand    = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            cand = rr_ptr + LANE_W'(k);
            if (!vld_p0 && eligible[cand]) begin
                vld_p0  = 1'b1;
                lane_p0 = cand;
            end
        end

        pop       = '0;
        bypass    = '0;
        fifo_pop  = '0;
        push_ok   = '0;
        fifo_push = '0;
        drop      = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            pop[i]       = vld_p0 && (lane_p0 == LANE_W'(i));
            bypass[i]    = pop[i] && (occ[i] == '0);
            fifo_pop[i]  = pop[i] && (occ[i] != '0);
            // The pop happens first, so a full lane that is being popped can still accept a push.
            push_ok[i]   = push_req[i] && quota_ok[i] &&
                           ((occ[i] != OCC_W'(FIFO_DEPTH)) || pop[i]);
            fifo_push[i] = push_ok[i] && !bypass[i];
            drop[i]      = push_req[i] && !push_ok[i];
        end

        data_p0 = bypass[lane_p0] ? lane_data[lane_p0] : fifo_mem[lane_p0][rd_ptr[lane_p0]];

        run_complete = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (written[i] != CNT_W'(ELEMS_PER_LANE) || occ[i] != '0) begin
                run_complete = 1'b0;
            end
        end
    end

    // Lane buffer storage holds data only, so it is not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (fifo_push[i]) begin
                fifo_mem[i][wr_ptr[i]] <= lane_data[i];
            end
        end
    end

    // p0 -> p1: arbitration result registered onto the RAM port
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            dut__dom__address <= '0;
            dut__dom__data    <= '0;
            dut__dom__enable  <= 1'b0;
            dut__dom__write   <= 1'b0;
            done              <= 1'b0;
            overflow_error    <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                rd_ptr[i]   <= '0;
                wr_ptr[i]   <= '0;
                occ[i]      <= '0;
                accepted[i] <= '0;
                written[i]  <= '0;
            end
        end else if (start) begin
            state            <= COLLECT;
            rr_ptr           <= '0;
            dut__dom__enable <= 1'b0;
            dut__dom__write  <= 1'b0;
            done             <= 1'b0;
            overflow_error   <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                rd_ptr[i]   <= '0;
                wr_ptr[i]   <= '0;
                occ[i]      <= '0;
                accepted[i] <= '0;
                written[i]  <= '0;
            end
        end else begin
            dut__dom__enable <= vld_p0;
            dut__dom__write  <= vld_p0;
            if (vld_p0) begin
                dut__dom__address <= ADDR_W'(lane_p0) * ADDR_W'(ELEMS_PER_LANE)
                                     + ADDR_W'(written[lane_p0]);
                dut__dom__data    <= writeback_value(data_p0);
                written[lane_p0]  <= written[lane_p0] + CNT_W'(1);
                rr_ptr            <= lane_p0 + LANE_W'(1);
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                if (fifo_push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (fifo_pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (push_ok[i])   accepted[i] <= accepted[i] + CNT_W'(1);
                occ[i] <= occ[i] + OCC_W'(fifo_push[i]) - OCC_W'(fifo_pop[i]);
            end
            if (|drop) overflow_error <= 1'b1;
            if (state == COLLECT && run_complete) begin
                state <= DONE;
                done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_output_writeback.sv
module tb_output_writeback;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] z0_element, z1_element, z2_element, z3_element;
    logic        z0_element_ready, z1_element_ready, z2_element_ready, z3_element_ready;
    logic [2:0]  dut__dom__address;
    logic [15:0] dut__dom__data;
    logic        dut__dom__enable, dut__dom__write, done, overflow_error;

    output_writeback dut (
        .clk(clk), .reset(reset), .start(start),
        .z0_element(z0_element), .z1_element(z1_element),
        .z2_element(z2_element), .z3_element(z3_element),
        .z0_element_ready(z0_element_ready), .z1_element_ready(z1_element_ready),
        .z2_element_ready(z2_element_ready), .z3_element_ready(z3_element_ready),
        .dut__dom__address(dut__dom__address), .dut__dom__data(dut__dom__data),
        .dut__dom__enable(dut__dom__enable), .dut__dom__write(dut__dom__write),
        .done(done), .overflow_error(overflow_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write log, recorded by the monitor only.
    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_cyc_q[$];
    int ew_bad = 0;
    int en_done_bad = 0;
    always @(negedge clk) begin
        if (dut__dom__enable === 1'b1) begin
            wr_addr_q.push_back(int'(dut__dom__address));
            wr_data_q.push_back(int'(dut__dom__data));
            wr_cyc_q.push_back(cyc);
        end
        if (dut__dom__enable !== dut__dom__write) ew_bad++;
        if (dut__dom__enable === 1'b1 && done === 1'b1) en_done_bad++;
    end

    // Summary of the log since a given index: per-address write count and last data.
    int obs_cnt[8];
    int obs_dat[8];
    int obs_last;
    task automatic collect_obs(input int base);
        for (int a = 0; a < 8; a++) begin obs_cnt[a] = 0; obs_dat[a] = -1; end
        obs_last = -1;
        for (int i = base; i < wr_addr_q.size(); i++) begin
            obs_cnt[wr_addr_q[i] & 7]++;
            obs_dat[wr_addr_q[i] & 7] = wr_data_q[i];
            obs_last = wr_cyc_q[i];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [3:0] m, input logic [15:0] d0, d1, d2, d3);
        z0_element = d0; z1_element = d1; z2_element = d2; z3_element = d3;
        {z3_element_ready, z2_element_ready, z1_element_ready, z0_element_ready} = m;
    endtask

    // One-cycle push on the lanes in m. Returns one cycle later, when a bypassed write is visible.
    task automatic drive(input logic [3:0] m, input logic [15:0] d0, d1, d2, d3);
        set_lanes(m, d0, d1, d2, d3);
        tick();
        {z3_element_ready, z2_element_ready, z1_element_ready, z0_element_ready} = 4'b0000;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0;
        set_lanes(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        set_lanes(4'b1111, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        tick(); tick();
        checks++; if (dut__dom__enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%0h exp=0", dut__dom__enable); end
        checks++; if (dut__dom__write !== 1'b0) begin failures++; $display("FAIL reset_write got=%0h exp=0", dut__dom__write); end
        checks++; if (dut__dom__address !== 3'd0) begin failures++; $display("FAIL reset_address got=%0h exp=0", dut__dom__address); end
        checks++; if (dut__dom__data !== 16'h0) begin failures++; $display("FAIL reset_data got=%0h exp=0", dut__dom__data); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", done); end
        checks++; if (overflow_error !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0h exp=0", overflow_error); end
        // Ready pulses while idle are ignored.
        reset = 1'b0;
        tick(); tick(); tick();
        checks++; if (dut__dom__enable !== 1'b0 || overflow_error !== 1'b0) begin failures++; $display("FAIL idle_ignore got en=%0h ovf=%0h exp 0 0", dut__dom__enable, overflow_error); end
        set_lanes(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic test_single_write();
        do_reset();
        do_start();
        drive(4'b0001, 16'h0011, 16'h0, 16'h0, 16'h0);
        checks++; if (dut__dom__enable !== 1'b1) begin failures++; $display("FAIL single_enable got=%0h exp=1", dut__dom__enable); end
        checks++; if (dut__dom__write !== 1'b1) begin failures++; $display("FAIL single_write got=%0h exp=1", dut__dom__write); end
        checks++; if (dut__dom__address !== 3'd0) begin failures++; $display("FAIL single_address got=%0h exp=0", dut__dom__address); end
        checks++; if (dut__dom__data !== 16'h0011) begin failures++; $display("FAIL single_data got=%0h exp=0011", dut__dom__data); end
        tick();
        checks++; if (dut__dom__enable !== 1'b0) begin failures++; $display("FAIL single_one_cycle got=%0h exp=0", dut__dom__enable); end
    endtask

    task automatic test_all_lanes_same_cycle();
        do_reset();
        do_start();
        drive(4'b1111, 16'h000A, 16'h000B, 16'h000C, 16'h000D);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dut__dom__enable !== 1'b1 || dut__dom__address !== 3'(2 * k) || dut__dom__data !== 16'(16'h000A + k)) begin
                failures++;
                $display("FAIL all_lanes_write%0d got en=%0h addr=%0d data=%0h exp en=1 addr=%0d data=%0h",
                         k, dut__dom__enable, dut__dom__address, dut__dom__data, 2 * k, 16'h000A + k);
            end
            tick();
        end
        checks++; if (dut__dom__enable !== 1'b0) begin failures++; $display("FAIL all_lanes_after got=%0h exp=0", dut__dom__enable); end
    endtask

    task automatic test_full_run_done();
        logic [15:0] v [8];
        int base, done_cyc, e0, d0;
        do_reset();
        do_start();
        base = wr_addr_q.size(); e0 = ew_bad; d0 = en_done_bad;
        for (int a = 0; a < 8; a++) v[a] = 16'($urandom);
        drive(4'b1111, v[0], v[2], v[4], v[6]);
        drive(4'b1111, v[1], v[3], v[5], v[7]);
        done_cyc = -1;
        for (int t = 0; t < 20; t++) begin
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            tick();
        end
        collect_obs(base);
        for (int a = 0; a < 8; a++) begin
            checks++;
            if (obs_cnt[a] != 1 || obs_dat[a] != int'(v[a])) begin
                failures++;
                $display("FAIL full_addr%0d got cnt=%0d data=%0h exp cnt=1 data=%0h", a, obs_cnt[a], obs_dat[a], v[a]);
            end
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL full_done_held got=%0h exp=1", done); end
        checks++; if (done_cyc != obs_last + 1) begin failures++; $display("FAIL full_done_timing got=%0d exp=%0d", done_cyc, obs_last + 1); end
        checks++; if (overflow_error !== 1'b0) begin failures++; $display("FAIL full_overflow got=%0h exp=0", overflow_error); end
        checks++; if (ew_bad != e0 || en_done_bad != d0) begin failures++; $display("FAIL full_strobes got en!=wr=%0d en_in_done=%0d exp 0 0", ew_bad - e0, en_done_bad - d0); end
        // Pulses in DONE are ignored.
        drive(4'b1111, 16'h1, 16'h2, 16'h3, 16'h4);
        tick();
        checks++; if (wr_addr_q.size() != base + 8 || overflow_error !== 1'b0) begin failures++; $display("FAIL done_ignore got writes=%0d ovf=%0h exp 8 0", wr_addr_q.size() - base, overflow_error); end
        do_start();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL restart_done got=%0h exp=0", done); end
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        do_start();
        base = wr_addr_q.size();
        drive(4'b1111, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
        drive(4'b1111, 16'h0101, 16'h0201, 16'h0301, 16'h0401);
        drive(4'b0100, 16'h0, 16'h0, 16'h0302, 16'h0);
        for (int t = 0; t < 12; t++) tick();
        collect_obs(base);
        checks++; if (obs_cnt[4] != 1 || obs_dat[4] != 'h0300) begin failures++; $display("FAIL ovf_addr4 got cnt=%0d data=%0h exp cnt=1 data=300", obs_cnt[4], obs_dat[4]); end
        checks++; if (obs_cnt[5] != 1 || obs_dat[5] != 'h0301) begin failures++; $display("FAIL ovf_addr5 got cnt=%0d data=%0h exp cnt=1 data=301", obs_cnt[5], obs_dat[5]); end
        checks++; if (wr_addr_q.size() - base != 8) begin failures++; $display("FAIL ovf_total got=%0d exp=8", wr_addr_q.size() - base); end
        checks++; if (overflow_error !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0h exp=1", overflow_error); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ovf_done got=%0h exp=1", done); end
        do_start();
        checks++; if (overflow_error !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%0h exp=0", overflow_error); end
    endtask

    task automatic test_reset_mid_run();
        int base;
        do_reset();
        do_start();
        base = wr_addr_q.size();
        drive(4'b1111, 16'h0A1, 16'h0B1, 16'h0C1, 16'h0D1);
        tick(); tick();
        checks++; if (wr_addr_q.size() - base != 3) begin failures++; $display("FAIL midrst_pre got=%0d exp=3", wr_addr_q.size() - base); end
        reset = 1'b1;
        tick();
        checks++;
        if (dut__dom__enable !== 1'b0 || dut__dom__write !== 1'b0 || dut__dom__address !== 3'd0 ||
            dut__dom__data !== 16'h0 || done !== 1'b0 || overflow_error !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs got en=%0h wr=%0h addr=%0h data=%0h done=%0h ovf=%0h exp all 0",
                     dut__dom__enable, dut__dom__write, dut__dom__address, dut__dom__data, done, overflow_error);
        end
        reset = 1'b0;
        base = wr_addr_q.size();
        for (int t = 0; t < 6; t++) drive(4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        checks++; if (wr_addr_q.size() != base) begin failures++; $display("FAIL midrst_nowrite got=%0d exp=0", wr_addr_q.size() - base); end
    endtask

    task automatic test_relu();
        logic [15:0] exp_neg;
`ifdef OUTPUT_RELU_EN
        exp_neg = 16'h0000;
`else
        exp_neg = 16'h8005;
`endif
        do_reset();
        do_start();
        drive(4'b0010, 16'h0, 16'h8005, 16'h0, 16'h0);
        checks++; if (dut__dom__address !== 3'd2 || dut__dom__data !== exp_neg) begin failures++; $display("FAIL relu_neg got addr=%0d data=%0h exp addr=2 data=%0h", dut__dom__address, dut__dom__data, exp_neg); end
        drive(4'b0010, 16'h0, 16'h7FFF, 16'h0, 16'h0);
        checks++; if (dut__dom__address !== 3'd3 || dut__dom__data !== 16'h7FFF) begin failures++; $display("FAIL relu_pos got addr=%0d data=%0h exp addr=3 data=7fff", dut__dom__address, dut__dom__data); end
    endtask

    // Random runs checked against a model: lane i keeps its first two pushes at
    // addresses 2i, 2i+1; any extra push sets overflow; done when every lane has two.
    task automatic test_random();
        logic [15:0] vals [4][3];
        int cnt [4];
        logic [3:0] m;
        logic [15:0] d [4];
        int base, done_cyc, e0, d0, nexp, all2;
        logic exp_ovf, exp_done;
        for (int it = 0; it < 20; it++) begin
            do_start();
            base = wr_addr_q.size(); e0 = ew_bad; d0 = en_done_bad;
            for (int l = 0; l < 4; l++) cnt[l] = 0;
            done_cyc = -1;
            for (int t = 0; t < 10; t++) begin
                all2 = 1;
                for (int l = 0; l < 4; l++) if (cnt[l] < 2) all2 = 0;
                m = 4'b0000;
                for (int l = 0; l < 4; l++) begin
                    d[l] = 16'($urandom);
                    if (all2 == 0 && cnt[l] < 3 && $urandom_range(0, 1) == 1) begin
                        m[l] = 1'b1;
                        vals[l][cnt[l]] = d[l];
                        cnt[l]++;
                    end
                end
                drive(m, d[0], d[1], d[2], d[3]);
                if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            end
            for (int t = 0; t < 14; t++) begin
                tick();
                if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            end
            exp_ovf = 1'b0; exp_done = 1'b1; nexp = 0;
            for (int l = 0; l < 4; l++) begin
                if (cnt[l] > 2) exp_ovf = 1'b1;
                if (cnt[l] < 2) exp_done = 1'b0;
                nexp += (cnt[l] > 2) ? 2 : cnt[l];
            end
            collect_obs(base);
            for (int a = 0; a < 8; a++) begin
                checks++;
                if ((a % 2) < cnt[a / 2]) begin
                    if (obs_cnt[a] != 1 || obs_dat[a] != int'(vals[a / 2][a % 2])) begin
                        failures++;
                        $display("FAIL rand%0d_addr%0d got cnt=%0d data=%0h exp cnt=1 data=%0h", it, a, obs_cnt[a], obs_dat[a], vals[a / 2][a % 2]);
                    end
                end else if (obs_cnt[a] != 0) begin
                    failures++;
                    $display("FAIL rand%0d_addr%0d got cnt=%0d exp cnt=0", it, a, obs_cnt[a]);
                end
            end
            checks++; if (wr_addr_q.size() - base != nexp) begin failures++; $display("FAIL rand%0d_total got=%0d exp=%0d", it, wr_addr_q.size() - base, nexp); end
            checks++; if (overflow_error !== exp_ovf) begin failures++; $display("FAIL rand%0d_overflow got=%0h exp=%0h", it, overflow_error, exp_ovf); end
            checks++; if (done !== exp_done) begin failures++; $display("FAIL rand%0d_done got=%0h exp=%0h", it, done, exp_done); end
            if (exp_done) begin
                checks++; if (done_cyc != obs_last + 1) begin failures++; $display("FAIL rand%0d_done_timing got=%0d exp=%0d", it, done_cyc, obs_last + 1); end
            end
            checks++; if (ew_bad != e0 || en_done_bad != d0) begin failures++; $display("FAIL rand%0d_strobes got en!=wr=%0d en_in_done=%0d exp 0 0", it, ew_bad - e0, en_done_bad - d0); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        set_lanes(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        test_reset();
        test_single_write();
        test_all_lanes_same_cycle();
        test_full_run_done();
        test_overflow();
        test_reset_mid_run();
        test_relu();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
